dcache_ctrl_nway: RTL and testbench

Parametrised N-way set-associative data-cache controller, the successor to the current 2-way controller. It sits between the CPU data port and the physical-memory (cacheline) port, alongside the tag/valid/dirty/data arrays and an external per-set PLRU array. New behaviour over the 2-way design:
- configurable way count with tree pseudo-LRU replacement;
- invalid-way-first victim selection;
- victim latched across the whole miss sequence;
- explicit write-back address select;
- fill write-enable gated on pmem_resp.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/plru_tree.sv | 46 ++++
 rtl/dcache_ctrl_nway.sv | 148 ++++++++++++++
 tb/tb_dcache_ctrl_nway.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the N-way data-cache controller.
//   state_t          : controller FSM states
//   DATA_SEL_*       : data_in_sel encodings (CPU write data vs. pmem line)
//   ADDR_SEL_*       : pmem_addr_sel encodings (CPU address vs. victim tag+index)
//   way_bits()       : width of a way index for a given associativity
package dcache_pkg;

    typedef enum logic [1:0] {
        LOOKUP     = 2'd0,
        WRITE_BACK = 2'd1,
        FILL       = 2'd2
    } state_t;

    localparam logic DATA_SEL_CPU    = 1'b0;
    localparam logic DATA_SEL_PMEM   = 1'b1;
    localparam logic ADDR_SEL_CPU    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;

    // At least one bit so a way index is always a legal vector.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set, purely combinational.
//   plru_in    : WAYS-1 tree bits; node 0 is the root, children of i are 2i+1 / 2i+2
//   access_way : way just accessed (hit)
//   victim_way : way selected by following the tree bits (0 = lower half)
//   plru_next  : plru_in with every node on access_way's path pointing away from it
module plru_tree
    import dcache_pkg::*;
#(
    parameter  int WAYS = 4,
    localparam int WB   = way_bits(WAYS)
) (
    input  logic [WAYS-2:0] plru_in,
    input  logic [WB-1:0]   access_way,
    output logic [WB-1:0]   victim_way,
    output logic [WAYS-2:0] plru_next
);

    // Padding to WAYS bits lets a WB-bit node index address the tree exactly.
    logic [WAYS-1:0] tree;
    logic [WAYS-1:0] nxt;
    logic [WB-1:0]   vnode;
    logic [WB-1:0]   unode;
    logic [WB-1:0]   path;

    always_comb begin
        tree       = {1'b0, plru_in};
        nxt        = tree;
        vnode      = '0;
        unode      = '0;
        path       = access_way;
        victim_way = '0;
        // Victim walk: each node bit picks the half holding the victim.
        for (int l = 0; l < WB; l++) begin
            victim_way = WB'({victim_way, tree[vnode]});
            vnode      = WB'(2 * int'(vnode) + 1 + int'(tree[vnode]));
        end
        // Update walk: MSB-first along the accessed way, point each node away.
        for (int l = 0; l < WB; l++) begin
            nxt[unode] = ~path[WB-1];
            unode      = WB'(2 * int'(unode) + 1 + int'(path[WB-1]));
            path       = path << 1;
        end
        plru_next = nxt[WAYS-2:0];
    end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// N-way set-associative data-cache controller (LOOKUP / WRITE_BACK / FILL).
//   CPU side   : mem_read, mem_write, mem_byte_enable256 -> mem_resp
//   Array side : hit_way, valid_out, dirty_out, plru_in ->
//                plru_next/load_plru, load_tag, load_valid/set_valid,
//                load_dirty/set_dirty, data_in_sel, write_enable
//   Pmem side  : pmem_addr_sel, pmem_read, pmem_write <- pmem_resp
// Outputs are combinational from state and inputs; the victim way is latched
// at the miss decision so array/PLRU changes during the miss cannot move it.
module dcache_ctrl_nway
    import dcache_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int LINE_BYTES = 32,
    localparam int WB         = way_bits(WAYS),
    localparam int WEW        = WAYS * LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [LINE_BYTES-1:0] mem_byte_enable256,
    output logic                  mem_resp,
    input  logic [WAYS-1:0]       hit_way,
    input  logic [WAYS-1:0]       valid_out,
    input  logic [WAYS-1:0]       dirty_out,
    input  logic [WAYS-2:0]       plru_in,
    output logic [WAYS-2:0]       plru_next,
    output logic                  load_plru,
    output logic [WAYS-1:0]       load_tag,
    output logic [WAYS-1:0]       load_valid,
    output logic                  set_valid,
    output logic [WAYS-1:0]       load_dirty,
    output logic                  set_dirty,
    output logic                  data_in_sel,
    output logic [WEW-1:0]        write_enable,
    output logic                  pmem_addr_sel,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic                  pmem_resp
);

    state_t        state;
    logic [WB-1:0] victim_q;
    logic [WB-1:0] hit_idx;
    logic [WB-1:0] inv_idx;
    logic [WB-1:0] plru_victim;
    logic [WB-1:0] victim;
    logic [WAYS-2:0] tree_next;
    logic          any_invalid;
    logic          req;
    logic          is_write;
    logic          hit;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;   // read wins when both are up
    assign hit      = |hit_way;

    // Descending scan so the lowest set bit wins (multi-hot hit is illegal).
    always_comb begin
        hit_idx     = '0;
        inv_idx     = '0;
        any_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_way[w]) hit_idx = WB'(w);
            if (!valid_out[w]) begin
                inv_idx     = WB'(w);
                any_invalid = 1'b1;
            end
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_in    (plru_in),
        .access_way (hit_idx),
        .victim_way (plru_victim),
        .plru_next  (tree_next)
    );

    assign victim = any_invalid ? inv_idx : plru_victim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOOKUP;
            victim_q <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (req && !hit) begin
                        victim_q <= victim;
                        state    <= dirty_out[victim] ? WRITE_BACK : FILL;
                    end
                end
                WRITE_BACK: if (pmem_resp) state <= FILL;
                FILL:       if (pmem_resp) state <= LOOKUP;
                default:    state <= LOOKUP;
            endcase
        end
    end

    always_comb begin
        mem_resp      = 1'b0;
        plru_next     = '0;
        load_plru     = 1'b0;
        load_tag      = '0;
        load_valid    = '0;
        set_valid     = 1'b0;
        load_dirty    = '0;
        set_dirty     = 1'b0;
        data_in_sel   = DATA_SEL_CPU;
        write_enable  = '0;
        pmem_addr_sel = ADDR_SEL_CPU;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        case (state)
            LOOKUP: begin
                if (req && hit) begin
                    mem_resp  = 1'b1;
                    load_plru = 1'b1;
                    plru_next = tree_next;
                    if (is_write) begin
                        write_enable = WEW'(mem_byte_enable256) << (int'(hit_idx) * LINE_BYTES);
                        load_dirty   = WAYS'(1) << hit_idx;
                        set_dirty    = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = ADDR_SEL_VICTIM;
                if (pmem_resp) load_dirty = WAYS'(1) << victim_q;
            end
            FILL: begin
                pmem_read   = 1'b1;
                data_in_sel = DATA_SEL_PMEM;
                // Array writes only when the line is actually on the bus.
                if (pmem_resp) begin
                    write_enable = {LINE_BYTES{1'b1}} << (int'(victim_q) * LINE_BYTES);
                    load_tag     = WAYS'(1) << victim_q;
                    load_valid   = WAYS'(1) << victim_q;
                    set_valid    = 1'b1;
                    load_dirty   = WAYS'(1) << victim_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
module tb_dcache_ctrl_nway;

    localparam int WAYS = 4;
    localparam int LB   = 32;
    localparam int WEW  = WAYS * LB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_read, mem_write;
    logic [LB-1:0]   be;
    logic            mem_resp;
    logic [WAYS-1:0] hit_way, valid_out, dirty_out;
    logic [WAYS-2:0] plru_in, plru_next;
    logic            load_plru;
    logic [WAYS-1:0] load_tag, load_valid, load_dirty;
    logic            set_valid, set_dirty, data_in_sel;
    logic [WEW-1:0]  write_enable;
    logic            pmem_addr_sel, pmem_read, pmem_write, pmem_resp;

    always #5 clk = ~clk;

    dcache_ctrl_nway #(.WAYS(WAYS), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable256(be),
        .mem_resp(mem_resp),
        .hit_way(hit_way), .valid_out(valid_out), .dirty_out(dirty_out),
        .plru_in(plru_in), .plru_next(plru_next), .load_plru(load_plru),
        .load_tag(load_tag), .load_valid(load_valid), .set_valid(set_valid),
        .load_dirty(load_dirty), .set_dirty(set_dirty),
        .data_in_sel(data_in_sel), .write_enable(write_enable),
        .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    typedef struct packed {
        logic            mem_resp;
        logic            load_plru;
        logic [WAYS-2:0] plru_next;
        logic [WAYS-1:0] load_tag;
        logic [WAYS-1:0] load_valid;
        logic            set_valid;
        logic [WAYS-1:0] load_dirty;
        logic            set_dirty;
        logic            data_in_sel;
        logic [WEW-1:0]  write_enable;
        logic            pmem_addr_sel;
        logic            pmem_read;
        logic            pmem_write;
    } outs_t;

    outs_t exp_q[$];
    string nm_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    mon_en = 0;

    function automatic outs_t sample();
        outs_t o;
        o.mem_resp      = mem_resp;
        o.load_plru     = load_plru;
        o.plru_next     = plru_next;
        o.load_tag      = load_tag;
        o.load_valid    = load_valid;
        o.set_valid     = set_valid;
        o.load_dirty    = load_dirty;
        o.set_dirty     = set_dirty;
        o.data_in_sel   = data_in_sel;
        o.write_enable  = write_enable;
        o.pmem_addr_sel = pmem_addr_sel;
        o.pmem_read     = pmem_read;
        o.pmem_write    = pmem_write;
        return o;
    endfunction

    // Monitor: every cycle with any output activity consumes one expectation.
    initial begin
        outs_t a, e;
        string s;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ($countones(hit_way) > 1) begin
                    n_fail++;
                    $display("FAIL hit_way_onehot: got %b, need at most one bit", hit_way);
                end
                a = sample();
                if (a != '0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL spurious_activity @%0t: got %h, want %h", $time, a, outs_t'(0));
                    end else begin
                        e = exp_q.pop_front();
                        s = nm_q.pop_front();
                        if (a !== e) begin
                            n_fail++;
                            $display("FAIL %s @%0t: got %h, want %h", s, $time, a, e);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string n, input outs_t e);
        exp_q.push_back(e);
        nm_q.push_back(n);
    endtask

    task automatic check_idle(input string n);
        outs_t a;
        #2;
        a = sample();
        n_cmp++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h, want all zero", n, a);
        end
    endtask

    task automatic clr();
        mem_read  = 0; mem_write = 0; be = '0; hit_way = '0;
        valid_out = 4'hF; dirty_out = '0; plru_in = '0; pmem_resp = 0;
    endtask

    function automatic outs_t hit_e(input logic [WAYS-2:0] pn);
        outs_t o = '0;
        o.mem_resp  = 1;
        o.load_plru = 1;
        o.plru_next = pn;
        return o;
    endfunction

    function automatic outs_t fill_e(input bit resp, input logic [WEW-1:0] we, input logic [WAYS-1:0] oh);
        outs_t o = '0;
        o.pmem_read   = 1;
        o.data_in_sel = 1;
        if (resp) begin
            o.write_enable = we;
            o.load_tag     = oh;
            o.load_valid   = oh;
            o.set_valid    = 1;
            o.load_dirty   = oh;
        end
        return o;
    endfunction

    function automatic outs_t wb_e(input bit resp, input logic [WAYS-1:0] oh);
        outs_t o = '0;
        o.pmem_write    = 1;
        o.pmem_addr_sel = 1;
        if (resp) o.load_dirty = oh;
        return o;
    endfunction

    localparam logic [WEW-1:0] WE_W0 = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    localparam logic [WEW-1:0] WE_W1 = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;
    localparam logic [WEW-1:0] WE_W2 = 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000;

    initial begin
        outs_t e;
        rst_n = 0;
        clr();
        repeat (2) cyc();
        rst_n  = 1;
        mon_en = 1;
        check_idle("reset_idle");

        // Read hit way 2, PLRU 000 -> 100
        cyc(); mem_read = 1; hit_way = 4'b0100; plru_in = 3'b000;
        expect_o("rd_hit_w2", hit_e(3'b100));
        cyc(); clr();

        // Write hit way 1 with BE 0xF -> bits [35:32], PLRU 000 -> 001
        cyc(); mem_write = 1; hit_way = 4'b0010; be = 32'h0000_000F;
        e = hit_e(3'b001);
        e.write_enable = 128'h0000_0000_0000_0000_0000_000F_0000_0000;
        e.load_dirty   = 4'b0010;
        e.set_dirty    = 1;
        expect_o("wr_hit_w1", e);
        cyc(); clr();

        // Read miss, way 2 is the lowest invalid, clean -> FILL, resp after 5
        cyc(); mem_read = 1; valid_out = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            cyc(); expect_o("miss_fill_wait", fill_e(0, '0, '0));
        end
        cyc(); pmem_resp = 1; expect_o("miss_fill_w2", fill_e(1, WE_W2, 4'b0100));
        cyc(); pmem_resp = 0; hit_way = 4'b0100; valid_out = 4'hF;
        expect_o("miss_relookup_w2", hit_e(3'b100));
        cyc(); clr();
        check_idle("after_miss_idle");

        // Read miss, all valid, PLRU 010 -> way 1, dirty -> write-back first.
        // Array inputs are scrambled during the miss; the latched victim holds.
        cyc(); mem_read = 1; plru_in = 3'b010; dirty_out = 4'b0010;
        cyc(); plru_in = 3'b111; valid_out = 4'b0000; dirty_out = 4'b0000;
        expect_o("wb_wait0", wb_e(0, '0));
        cyc(); expect_o("wb_wait1", wb_e(0, '0));
        cyc(); pmem_resp = 1; expect_o("wb_done_w1", wb_e(1, 4'b0010));
        cyc(); pmem_resp = 0; expect_o("wb_fill_wait", fill_e(0, '0, '0));
        cyc(); pmem_resp = 1; expect_o("wb_fill_w1", fill_e(1, WE_W1, 4'b0010));
        cyc(); pmem_resp = 0; hit_way = 4'b0010; plru_in = 3'b010; valid_out = 4'hF;
        expect_o("wb_relookup_w1", hit_e(3'b001));
        cyc(); clr();

        // Reset during FILL; pmem_resp in LOOKUP afterwards is ignored
        cyc(); mem_read = 1; valid_out = 4'b0111;
        cyc(); expect_o("rst_fill_wait0", fill_e(0, '0, '0));
        cyc(); rst_n = 0; expect_o("rst_fill_wait1", fill_e(0, '0, '0));
        cyc(); rst_n = 1; mem_read = 0; valid_out = 4'hF; pmem_resp = 1;
        check_idle("rst_in_fill_lookup");
        cyc(); check_idle("pmem_resp_in_lookup");
        cyc(); clr();

        // Read and write together on a hit: read wins, no write side effects
        cyc(); mem_read = 1; mem_write = 1; hit_way = 4'b1000; be = '1; plru_in = 3'b000;
        expect_o("rd_wr_hit_w3", hit_e(3'b000));
        cyc(); clr();

        // Miss with the request dropped mid-sequence; lowest invalid is way 1
        cyc(); mem_read = 1; valid_out = 4'b0101; dirty_out = 4'b1101;
        cyc(); clr(); expect_o("drop_fill_wait", fill_e(0, '0, '0));
        cyc(); pmem_resp = 1; expect_o("drop_fill_w1", fill_e(1, WE_W1, 4'b0010));
        cyc(); pmem_resp = 0; hit_way = 4'b0010;
        check_idle("drop_no_resp");

        cyc(); clr();
        repeat (3) cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
